rst_cipher_ctrl: RTL and testbench

//  Message-level sequencer for the rst_cipher datapath.
//  - Latches a 96-bit key on start, then clears the cipher's rotation table by resetting it.
//  - Streams plaintext characters into the cipher, one per cycle, using credit-based flow control.
//  - Buffers ciphertext pairs in an output FIFO with ready/valid backpressure.
//  - Reports per-message statistics when the message is complete.

---
 rtl/rst_cipher_ctrl.sv | 157 +++++++++++++++
 tb/tb_rst_cipher_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_cipher_ctrl.sv
// Message sequencer for the rst_cipher datapath: key load, cipher table reset,
// credit-limited character issue and a ciphertext output FIFO.
module rst_cipher_ctrl #(
    parameter int unsigned OUT_DEPTH = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [95:0]      key,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_char,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_ctxt,
    output logic             msg_done,
    output logic [CNT_W-1:0] msg_char_cnt,
    output logic [CNT_W-1:0] msg_err_cnt,
    output logic             proto_err,
    output logic             cph_rst_n,
    output logic [95:0]      cph_key,
    output logic             cph_ptxt_valid,
    output logic [7:0]       cph_ptxt_char,
    input  logic [15:0]      cph_ctxt_str,
    input  logic             cph_ctxt_ready,
    input  logic             cph_err_invalid_ptxt_char
);

    localparam int unsigned AW = $clog2(OUT_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DepthSum  = (CW + 1)'(OUT_DEPTH);
    localparam logic [CW-1:0] DepthCnt = CW'(OUT_DEPTH);

    typedef enum logic [2:0] {StIdle, StLoad, StSetup, StRun, StDrain, StDone} state_e;
    state_e state_q, state_d;

    logic             cph_rst_n_q;
    logic [95:0]      key_q;
    logic             ptxt_valid_q;
    logic [7:0]       ptxt_char_q;
    logic [CW-1:0]    inflight_q;
    logic [CNT_W-1:0] char_cnt_q, err_cnt_q;
    logic             proto_err_q;
    logic [CW-1:0]    fifo_cnt_q;
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [15:0]      mem [OUT_DEPTH];

    logic          fifo_empty, fifo_full, take, accept, pop, push;
    logic          rsp_any, rsp_bad, rsp_ok;
    logic [CW:0]   credit_sum;

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == DepthCnt);
    assign credit_sum = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
    assign take       = (state_q == StIdle) && fifo_empty && start;
    assign accept     = in_valid && in_ready;
    assign pop        = out_valid && out_ready;

    // A response with nothing outstanding, or both strobes at once, breaks the cipher contract.
    assign rsp_any = cph_ctxt_ready || cph_err_invalid_ptxt_char;
    assign rsp_bad = rsp_any && ((inflight_q == '0) ||
                                 (cph_ctxt_ready && cph_err_invalid_ptxt_char));
    assign rsp_ok  = rsp_any && !rsp_bad;
    assign push    = rsp_ok && cph_ctxt_ready && (!fifo_full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (take) state_d = StLoad;
            StLoad:  state_d = StSetup;
            StSetup: state_d = StRun;
            StRun:   if (accept && in_last) state_d = StDrain;
            StDrain: if (inflight_q == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StRun) && (credit_sum < DepthSum);
        msg_done  = (state_q == StDone);
        busy      = !((state_q == StIdle) && fifo_empty);
        out_valid = !fifo_empty;
        out_ctxt  = fifo_empty ? 16'h0 : mem[rptr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cph_rst_n_q  <= 1'b0;
            key_q        <= '0;
            ptxt_valid_q <= 1'b0;
            ptxt_char_q  <= '0;
            inflight_q   <= '0;
            char_cnt_q   <= '0;
            err_cnt_q    <= '0;
            proto_err_q  <= 1'b0;
            fifo_cnt_q   <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
        end else begin
            // The cipher table is cleared while idle and during the key-load cycle.
            cph_rst_n_q  <= !((state_d == StIdle) || (state_d == StLoad));
            ptxt_valid_q <= accept;
            if (take) key_q <= key;
            if (accept) ptxt_char_q <= in_char;
            if (rsp_bad) proto_err_q <= 1'b1;

            if (accept && !rsp_ok) begin
                inflight_q <= inflight_q + 1'b1;
            end else if (!accept && rsp_ok) begin
                inflight_q <= inflight_q - 1'b1;
            end

            if (take) begin
                char_cnt_q <= '0;
                err_cnt_q  <= '0;
            end else begin
                if (accept && (char_cnt_q != '1)) char_cnt_q <= char_cnt_q + 1'b1;
                if (rsp_ok && cph_err_invalid_ptxt_char && (err_cnt_q != '1)) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
            end

            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + 1'b1;
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= cph_ctxt_str;
    end

    assign cph_rst_n      = cph_rst_n_q;
    assign cph_key        = key_q;
    assign cph_ptxt_valid = ptxt_valid_q;
    assign cph_ptxt_char  = ptxt_char_q;
    assign msg_char_cnt   = char_cnt_q;
    assign msg_err_cnt    = err_cnt_q;
    assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_rst_cipher_ctrl.sv
// Scoreboard bench for rst_cipher_ctrl with a small behavioural cipher model
// (rotating key table, lowercase-only plaintext).
module tb_rst_cipher_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [95:0] key;
    logic        busy, in_valid, in_ready, in_last, out_valid, out_ready;
    logic [7:0]  in_char;
    logic [15:0] out_ctxt;
    logic        msg_done, proto_err, cph_rst_n, cph_ptxt_valid;
    logic [15:0] msg_char_cnt, msg_err_cnt;
    logic [95:0] cph_key;
    logic [7:0]  cph_ptxt_char;
    logic [15:0] m_str = 16'h0;
    logic        m_ready = 1'b0;
    logic        m_err = 1'b0;
    logic        inject = 1'b0;

    localparam logic [95:0] KEY = "abcdefghijkl";
    localparam logic [95:0] ALT = "zyxwvutsrqpo";

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    rst_cipher_ctrl #(.OUT_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctxt(out_ctxt),
        .msg_done(msg_done), .msg_char_cnt(msg_char_cnt), .msg_err_cnt(msg_err_cnt),
        .proto_err(proto_err), .cph_rst_n(cph_rst_n), .cph_key(cph_key),
        .cph_ptxt_valid(cph_ptxt_valid), .cph_ptxt_char(cph_ptxt_char),
        .cph_ctxt_str(m_str), .cph_ctxt_ready(m_ready), .cph_err_invalid_ptxt_char(m_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] kc(input logic [95:0] k, input int i);
        return k[95-8*i -: 8];
    endfunction

    // Cipher model: one response per issued char, next cycle; table index advances by 6.
    int idx = 0;
    int r;
    always @(posedge clk) begin
        m_ready <= 1'b0;
        m_err   <= 1'b0;
        if (!cph_rst_n) begin
            idx <= 0;
        end else if (cph_ptxt_valid) begin
            if (cph_ptxt_char >= 8'h61 && cph_ptxt_char <= 8'h7a) begin
                r = (idx + int'(cph_ptxt_char - 8'h61)) % 12;
                m_str   <= {kc(cph_key, r), kc(cph_key, (r + 1) % 12)};
                m_ready <= 1'b1;
                idx     <= (idx + 6) % 12;
            end else begin
                m_err <= 1'b1;
            end
        end
        if (inject) begin
            m_ready <= 1'b1;
            m_str   <= 16'h1234;
        end
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake pops one expected ciphertext.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got %0h expected none", out_ctxt);
            end else begin
                check("out_ctxt", {80'h0, out_ctxt}, {80'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_ctxt"}, out_ctxt, 0);
        check({tag, "_msg_done"}, msg_done, 0);
        check({tag, "_cnts"}, {msg_char_cnt, msg_err_cnt}, 0);
        check({tag, "_proto_err"}, proto_err, 0);
        check({tag, "_cph_rst_n"}, cph_rst_n, 0);
        check({tag, "_cph_key"}, cph_key, 0);
        check({tag, "_cph_ptxt"}, {cph_ptxt_valid, cph_ptxt_char}, 0);
    endtask

    task automatic start_msg(input logic [95:0] k);
        start = 1'b1;
        key   = k;
        tick();
        start = 1'b0;
        check("load_key", cph_key, k);
        check("load_cph_rst_n", cph_rst_n, 0);
        tick();
        check("setup_cph_rst_n", cph_rst_n, 1);
        check("setup_in_ready", in_ready, 0);
        tick();
        check("run_in_ready", in_ready, 1);
    endtask

    task automatic send(input logic [7:0] c, input logic last);
        int budget = 100;
        in_valid = 1'b1;
        in_char  = c;
        in_last  = last;
        while (!in_ready && budget > 0) begin
            tick();
            budget--;
        end
        check("accept_in_time", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int pulses = 0;
        int budget = 200;
        while (budget > 0 && !(pulses > 0 && !busy)) begin
            if (msg_done) pulses++;
            tick();
            budget--;
        end
        check({tag, "_done_pulses"}, pulses, 1);
        check({tag, "_idle"}, busy, 0);
    endtask

    logic [15:0] bp_exp [8] = '{"ab", "hi", "cd", "jk", "ef", "la", "gh", "bc"};

    initial begin
        int i;
        int budget;
        rst = 1'b1; start = 1'b0; key = '0; in_valid = 1'b0; in_char = '0;
        in_last = 1'b0; out_ready = 1'b1;
        #3;
        check_reset_outputs("por");
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Basic message with one rejected character.
        start_msg(KEY);
        exp_q.push_back("ab");
        exp_q.push_back("gh");
        send("a", 0);
        send("-", 0);
        send("a", 1);
        wait_done("basic");
        check("basic_char_cnt", msg_char_cnt, 3);
        check("basic_err_cnt", msg_err_cnt, 1);

        // Latency: accept -> issue next cycle -> visible three cycles after accept.
        start_msg(KEY);
        exp_q.push_back("ab");
        in_valid = 1'b1; in_char = "a"; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("lat_issue", {cph_ptxt_valid, cph_ptxt_char}, {1'b1, 8'h61});
        check("lat_t1_out_valid", out_valid, 0);
        tick();
        check("lat_t2_out_valid", out_valid, 0);
        tick();
        check("lat_t3_out_valid", out_valid, 1);
        wait_done("lat");
        check("lat_cnts", {msg_char_cnt, msg_err_cnt}, {16'd1, 16'd0});

        // start is ignored while the FIFO still holds results after DONE.
        out_ready = 1'b0;
        start_msg(KEY);
        exp_q.push_back("ab");
        send("a", 1);
        budget = 50;
        while (!msg_done && budget > 0) begin
            tick();
            budget--;
        end
        check("fifoblk_done_seen", msg_done, 1);
        tick();
        check("fifoblk_out_valid", out_valid, 1);
        start = 1'b1; key = ALT;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("fifoblk_key_kept", cph_key, KEY);
        check("fifoblk_still_idle", cph_rst_n, 0);
        check("fifoblk_busy", busy, 1);
        out_ready = 1'b1;
        budget = 20;
        while (busy && budget > 0) begin
            tick();
            budget--;
        end
        check("fifoblk_drained", busy, 0);

        // Backpressure: only OUT_DEPTH credits available with out_ready low.
        out_ready = 1'b0;
        start_msg(KEY);
        for (int k = 0; k < 8; k++) exp_q.push_back(bp_exp[k]);
        i = 0;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_char = 8'h61 + 8'(i);
            in_last = (i == 7);
            if (in_ready) i++;
            tick();
        end
        check("bp_accepted", i, 4);
        check("bp_in_ready_low", in_ready, 0);
        in_valid = 1'b0;
        start = 1'b1; key = ALT;
        tick();
        start = 1'b0;
        check("bp_run_key_kept", cph_key, KEY);
        out_ready = 1'b1;
        in_valid = 1'b1;
        budget = 100;
        while (i < 8 && budget > 0) begin
            in_char = 8'h61 + 8'(i);
            in_last = (i == 7);
            if (in_ready) i++;
            tick();
            budget--;
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("bp_all_accepted", i, 8);
        wait_done("bp");
        check("bp_char_cnt", msg_char_cnt, 8);

        // Reset mid-message with two characters outstanding.
        start_msg(KEY);
        send("a", 0);
        send("b", 0);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        start_msg(KEY);
        exp_q.push_back("ab");
        send("a", 1);
        wait_done("postrst");

        // Spurious cipher strobe while idle.
        inject = 1'b1;
        tick();
        inject = 1'b0;
        repeat (2) tick();
        check("proto_err_set", proto_err, 1);
        check("proto_fifo_unchanged", out_valid, 0);
        repeat (3) tick();
        check("proto_err_sticky", proto_err, 1);
        rst = 1'b1;
        #1;
        check("proto_err_cleared", proto_err, 0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
